seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port multiplicand, input, N bits: operand A; captured on the accepted start edge.
REQ-006 SHALL have port multiplier, input, N bits: operand B; captured on the accepted start edge.
REQ-007 SHALL have port product, output, 2N bits: registered result; holds its value between operations.
REQ-008 SHALL have port busy, output, 1 bit: high in LOAD and CALC.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse in DONE; product is valid in the same cycle.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, CALC and DONE.
REQ-011 Transition IDLE->LOAD SHALL occur when start=1, capturing multiplicand and multiplier; with start=0 the FSM SHALL stay in IDLE.
REQ-012 LOAD SHALL last one cycle, clear the 2N-bit accumulator and bit counter to 0, then go to CALC.
REQ-013 CALC SHALL last exactly N cycles, one per iteration i = 0..N-1: if B bit i=1, add A zero-extended and shifted left by i into the accumulator; the 2N-bit sum SHALL never overflow.
REQ-014 After iteration N-1 the FSM SHALL go to DONE, load product from the accumulator, then return to IDLE unconditionally.
REQ-015 Latency SHALL be fixed: done asserts exactly N+2 cycles after the accepted start edge, independent of operand values.
REQ-016 start SHALL be ignored in LOAD, CALC and DONE; captured operands SHALL NOT change mid-operation even if the inputs toggle.
REQ-017 start held high continuously SHALL produce back-to-back operations: IDLE one cycle, then LOAD.
REQ-018 Operands of zero SHALL still take the full latency and yield product 0.
REQ-019 product SHALL update only in DONE; it SHALL keep the previous result during LOAD and CALC.

Reset
REQ-020 On rst=0, asynchronously: state SHALL be IDLE; accumulator, counter, captured operands and product SHALL be 0; busy and done SHALL be 0.
REQ-021 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.

Configuration
REQ-022 Macro SEQ_MULT_SIGNED_EN defined: operands SHALL be two's complement.
  - LOAD SHALL take operand magnitudes.
  - DONE SHALL negate the result when the operand signs differ.
  - Latency SHALL be unchanged.
  - Most-negative input: magnitude 2^(N-1), handled exactly.
REQ-023 Macro SEQ_MULT_SIGNED_EN undefined: operands SHALL be unsigned and no sign logic SHALL be present.

Structure
REQ-024 Package seq_mult_pkg SHALL hold:
  - the FSM state enum (IDLE, LOAD, CALC, DONE);
  - the default width constant (4);
  - the counter-width function ($clog2(N)+1).
REQ-025 The accumulator and product holding SHALL instantiate the existing clearable register sub-module (width 2N, clear driven in LOAD); the FSM and adder SHALL be local.

Verification
REQ-026 N=4, unsigned:
  - 3 x 5 -> product=15, done exactly 6 cycles after start;
  - 15 x 15 -> product=225 (0xE1).
REQ-027 0 x 9 -> product=0, busy high 5 cycles, done at cycle 6.
REQ-028 Start pulsed again during CALC with different operands -> ignored; first result correct; busy stays contiguous.
REQ-029 rst pulsed low at CALC iteration 2 -> all outputs 0 immediately, no done; a following 2 x 7 -> 14.
REQ-030 SEQ_MULT_SIGNED_EN, N=4:
  - -3 x 5 -> product=8'hF1;
  - -8 x -8 -> 8'h40;
  - -8 x 1 -> 8'hF8.
REQ-031 start held high for 20 cycles -> done pulses every 7 cycles, each with the correct product.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   state_e    - controller states (IDLE, LOAD, CALC, DONE)
//   DEFAULT_N  - default operand width in bits
//   cnt_width  - width of the iteration counter, sized so it can hold N
// ---------------------------------------------------------------------------
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_N = 4;

  // One extra bit so the counter can step past the last iteration index.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_reg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_reg
// Clearable, load-enabled register used for the accumulator and the product.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, forces q to 0
//   clr  - synchronous clear, takes priority over en
//   en   - load d on the next rising edge
//   d    - data in  [W-1:0]
//   q    - data out [W-1:0]
// ---------------------------------------------------------------------------
module seq_multiplier_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-and-add multiplier: one partial product per cycle, with a
// fixed latency of N+2 cycles from the accepted start edge to the done pulse.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   start        - begin a multiplication (only looked at in IDLE)
//   multiplicand - operand A [N-1:0], captured on the accepted start edge
//   multiplier   - operand B [N-1:0], captured on the accepted start edge
//   product      - registered result [2N-1:0], held between operations
//   busy         - high while in LOAD and CALC
//   done         - one-cycle pulse in DONE, product valid in the same cycle
// Configuration:
//   SEQ_MULT_SIGNED_EN - when defined, operands are two's complement; LOAD
//                        converts them to magnitudes and the final result is
//                        negated when the operand signs differ.
// ---------------------------------------------------------------------------
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = cnt_width(N);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_sum;
  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  prod_next;
  logic [2*N-1:0]  prod_q;
  logic            cur_bit;
  logic            last_iter;
  logic            acc_clr;
  logic            acc_en;

`ifdef SEQ_MULT_SIGNED_EN
  logic            neg_q, neg_d;

  // The most-negative value maps to 2^(N-1), which still fits as an
  // unsigned N-bit magnitude.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? ((~v) + N'(1)) : v;
  endfunction
`endif

  // Datapath: select multiplier bit i and add A<<i when it is set. The
  // accumulator is 2N bits wide, so the running sum can never overflow.
  // The product register is loaded straight from the adder on the last
  // iteration so the result is already present during the DONE cycle.
  always_comb begin
    cur_bit   = |(b_q & ({{(N-1){1'b0}}, 1'b1} << cnt_q));
    addend    = {{N{1'b0}}, a_q} << cnt_q;
    acc_sum   = cur_bit ? (acc + addend) : acc;
    last_iter = (state_q == CALC) && (cnt_q == CW'(N-1));
    acc_clr   = (state_q == LOAD);
    acc_en    = (state_q == CALC);
`ifdef SEQ_MULT_SIGNED_EN
    prod_next = neg_q ? (-acc_sum) : acc_sum;
`else
    prod_next = acc_sum;
`endif
  end

  // Next-state logic. Operands are only written on the start edge (and, in
  // signed mode, once more in LOAD), so input activity during an operation
  // cannot disturb it. busy and done are derived from the next state so that
  // they come out of flops aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = CALC;
`ifdef SEQ_MULT_SIGNED_EN
        a_d     = magnitude(a_q);
        b_d     = magnitude(b_q);
        neg_d   = a_q[N-1] ^ b_q[N-1];
`endif
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // Controller and operand state, including the registered busy/done outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  seq_multiplier_reg #(.W(2*N)) u_acc_reg (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (acc_sum),
    .q   (acc)
  );

  // The product register never needs a synchronous clear; it only changes
  // when a finished result is handed over.
  seq_multiplier_reg #(.W(2*N)) u_prod_reg (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (last_iter),
    .d   (prod_next),
    .q   (prod_q)
  );

  assign product = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier (N=4). Follows SEQ_MULT_SIGNED_EN
// so the same bench covers the unsigned and the signed build.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int N        = 4;
  localparam int MAX_WAIT = 20;
  localparam int EXP_LAT  = N + 2;
  localparam int EXP_BUSY = N + 1;
  localparam int PERIOD   = N + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int nVectors     = 0;
  int nMiscompares = 0;

  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer multiplication truncated to 2N bits.
  function automatic logic [2*N-1:0] refProduct(input logic [N-1:0] a, input logic [N-1:0] b);
    int ia;
    int ib;
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'(a);
    ib = int'(b);
`endif
    p = ia * ib;
    return p[2*N-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE. While it is in flight, start and the
  // operand inputs are scrambled every cycle; none of that may leak into the
  // result. Returns at the falling edge of the cycle in which done is seen.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               output logic [2*N-1:0] prod, output int lat,
                               output int busyCnt, output bit prodChanged);
    logic [2*N-1:0] prevProd;
    @(negedge clk);
    prevProd     = product;
    prodChanged  = 1'b0;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    lat     = 1;
    busyCnt = 0;
    while (!done && lat < MAX_WAIT) begin
      busyCnt += int'(busy);
      if (product !== prevProd) prodChanged = 1'b1;
      start        = 1'($urandom_range(0, 1));
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    prod  = product;
  endtask

  task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] expProd);
    logic [2*N-1:0] prod;
    int lat;
    int busyCnt;
    bit prodChanged;
    applyStimulus(a, b, prod, lat, busyCnt, prodChanged);
    checkOutput({tag, " done seen"}, 64'(done), 64'(1));
    checkOutput({tag, " product"}, 64'(prod), 64'(expProd));
    checkOutput({tag, " latency"}, 64'(lat), 64'(EXP_LAT));
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(EXP_BUSY));
    checkOutput({tag, " product held"}, 64'(prodChanged), 64'(0));
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 64'(done), 64'(0));
    checkOutput({tag, " product kept"}, 64'(product), 64'(expProd));
  endtask

  logic [N-1:0] opA[PERIOD*4+1];
  logic [N-1:0] opB[PERIOD*4+1];

  initial begin
    int doneCnt;
    bit expDone;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    rst          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Fixed vectors, including the boundary operands.
`ifdef SEQ_MULT_SIGNED_EN
    vecs[0] = '{a: 4'hD, b: 4'h5, prod: 8'hF1};
    vecs[1] = '{a: 4'h8, b: 4'h8, prod: 8'h40};
    vecs[2] = '{a: 4'h8, b: 4'h1, prod: 8'hF8};
    vecs[3] = '{a: 4'h7, b: 4'h7, prod: 8'h31};
    vecs[4] = '{a: 4'hF, b: 4'hF, prod: 8'h01};
    vecs[5] = '{a: 4'h0, b: 4'h8, prod: 8'h00};
    vecs[6] = '{a: 4'h7, b: 4'h8, prod: 8'hC8};
    vecs[7] = '{a: 4'h8, b: 4'h7, prod: 8'hC8};
`else
    vecs[0] = '{a: 4'h3, b: 4'h5, prod: 8'h0F};
    vecs[1] = '{a: 4'hF, b: 4'hF, prod: 8'hE1};
    vecs[2] = '{a: 4'h0, b: 4'h9, prod: 8'h00};
    vecs[3] = '{a: 4'h9, b: 4'h0, prod: 8'h00};
    vecs[4] = '{a: 4'h1, b: 4'h1, prod: 8'h01};
    vecs[5] = '{a: 4'hF, b: 4'h1, prod: 8'h0F};
    vecs[6] = '{a: 4'h8, b: 4'h8, prod: 8'h40};
    vecs[7] = '{a: 4'hA, b: 4'h6, prod: 8'h3C};
`endif

    repeat (2) @(negedge clk);
    checkOutput("reset product", 64'(product), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle busy", 64'(busy), 64'(0));

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);
    end

    for (int i = 0; i < 30; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      runOp($sformatf("rand%0d", i), ra, rb, refProduct(ra, rb));
    end

    // Abort in the middle of CALC: leave a nonzero product first so the
    // asynchronous clear is visible.
    runOp("pre-abort", 4'h3, 4'h5, 8'h0F);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'h5;
    multiplier   = 4'h3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort busy before", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    checkOutput("abort product", 64'(product), 64'(0));
    checkOutput("abort busy", 64'(busy), 64'(0));
    checkOutput("abort done", 64'(done), 64'(0));
    @(negedge clk);
    rst     = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      doneCnt += int'(done);
    end
    checkOutput("abort no done", 64'(doneCnt), 64'(0));
    runOp("post-abort", 4'h2, 4'h7, 8'h0E);

    // start held high: a new operation is accepted every PERIOD cycles.
    for (int n = 0; n <= PERIOD * 4; n++) begin
      @(negedge clk);
      expDone = (n >= EXP_LAT) && (((n - EXP_LAT) % PERIOD) == 0);
      checkOutput($sformatf("b2b done @%0d", n), 64'(done), 64'(expDone));
      if (expDone) begin
        checkOutput($sformatf("b2b product @%0d", n), 64'(product),
                    64'(refProduct(opA[n-EXP_LAT], opB[n-EXP_LAT])));
      end
      opA[n]       = N'($urandom);
      opB[n]       = N'($urandom);
      multiplicand = opA[n];
      multiplier   = opB[n];
      start        = (n <= PERIOD * 3);
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
